// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: DE decode, MW control register, flush/forwarding and interrupt entry for a 3-stage RV32I pipe.
// Define PIPE_FWD_EN for MW->DE forwarding; when it is undefined, RAW hazards stall for one cycle instead.
module pipeline_ctrl #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] inst_de,
    input  logic [BUS_WIDTH-1:0] inst_mw,
    input  logic                 br_taken,
    input  logic                 irq,
    input  logic                 mie,
    output logic                 flush,
    output logic                 stall,
    output logic                 fwd_a,
    output logic                 fwd_b,
    output logic                 rf_wen_mw,
    output logic                 mem_rd_mw,
    output logic                 mem_wr_mw,
    output logic [1:0]           wb_sel_mw,
    output logic                 csr_wr_mw,
    output logic                 trap_req,
    output logic                 irq_ack
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {IDLE, DRAIN, TRAP, TRAP_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [5:0]  ctrl_q, ctrl_d;
    logic [6:0]  op_de, op_mw;
    logic [2:0]  f3_de;
    logic [4:0]  rd_de, rs1_de, rs2_de, rd_mw;
    logic        dec_rf, dec_mrd, dec_mwr, dec_csr, use_rs1, use_rs2;
    logic [1:0]  dec_wb;
    logic        mret_mw, mw_ctl, raw_a, raw_b;
    logic        unused_de;

    assign op_de     = inst_de[6:0];
    assign rd_de     = inst_de[11:7];
    assign f3_de     = inst_de[14:12];
    assign rs1_de    = inst_de[19:15];
    assign rs2_de    = inst_de[24:20];
    assign unused_de = ^inst_de[BUS_WIDTH-1:25];
    assign op_mw     = inst_mw[6:0];
    assign rd_mw     = inst_mw[11:7];
    assign mret_mw   = inst_mw == BUS_WIDTH'(32'h3020_0073);
    assign mw_ctl    = (op_mw == OP_BRANCH) | (op_mw == OP_JAL) | (op_mw == OP_JALR) | mret_mw;

    // CSR immediate forms carry a zimm in the rs1 field, so they read no register
    always_comb begin
        dec_rf  = 1'b0;
        dec_mrd = 1'b0;
        dec_mwr = 1'b0;
        dec_wb  = 2'd0;
        dec_csr = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (op_de)
            OP_LUI, OP_AUIPC: dec_rf = 1'b1;
            OP_JAL: begin
                dec_rf = 1'b1;
                dec_wb = 2'd2;
            end
            OP_JALR: begin
                dec_rf  = 1'b1;
                dec_wb  = 2'd2;
                use_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                dec_rf  = 1'b1;
                dec_mrd = 1'b1;
                dec_wb  = 2'd1;
                use_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec_mwr = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM: begin
                dec_rf  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_REG: begin
                dec_rf  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_SYSTEM: begin
                dec_rf  = f3_de != 3'd0;
                dec_wb  = (f3_de != 3'd0) ? 2'd3 : 2'd0;
                dec_csr = f3_de != 3'd0;
                use_rs1 = (f3_de != 3'd0) & ~f3_de[2];
            end
            default: ;
        endcase
    end

    assign raw_a = rf_wen_mw & use_rs1 & (rs1_de != 5'd0) & (rs1_de == rd_mw);
    assign raw_b = rf_wen_mw & use_rs2 & (rs2_de != 5'd0) & (rs2_de == rd_mw);

    always_comb begin
        state_d  = state_q;
        trap_req = 1'b0;
        irq_ack  = 1'b0;
        case (state_q)
            IDLE:  if (irq && mie) state_d = (mw_ctl || br_taken) ? DRAIN : TRAP;
            DRAIN: state_d = irq ? TRAP : IDLE;
            TRAP: begin
                trap_req = 1'b1;
                state_d  = TRAP_FLUSH;
            end
            TRAP_FLUSH: begin
                irq_ack = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign flush  = br_taken | mret_mw | trap_req | irq_ack;
    assign ctrl_d = (state_q == TRAP || stall) ? 6'd0
                  : {dec_rf & (rd_de != 5'd0), dec_mrd, dec_mwr, dec_wb, dec_csr};
    assign {rf_wen_mw, mem_rd_mw, mem_wr_mw, wb_sel_mw, csr_wr_mw} = ctrl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ctrl_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef PIPE_FWD_EN
    assign fwd_a = raw_a;
    assign fwd_b = raw_b;
    assign stall = 1'b0;
`else
    logic stall_q;
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
    // The flag keeps a held DE instruction from stalling twice in a row
    assign stall = (raw_a | raw_b) & ~stall_q & ~flush;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= 1'b0;
        else      stall_q <= stall;
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl; expectations follow PIPE_FWD_EN when it is defined.
module tb_pipeline_ctrl;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI1 = 32'h0050_0093;
    localparam logic [31:0] ADD2  = 32'h0010_8133;
    localparam logic [31:0] ADD0  = 32'h0010_8033;
    localparam logic [31:0] ADDI3 = 32'h0010_0193;
    localparam logic [31:0] LW5   = 32'h0001_2283;
    localparam logic [31:0] SW5   = 32'h0051_2023;
    localparam logic [31:0] CSRW6 = 32'h3000_9373;
    localparam logic [31:0] JAL1  = 32'h0000_00EF;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] MRET  = 32'h3020_0073;
    localparam int S_IDLE = 0, S_DRAIN = 1, S_TRAP = 2, S_TF = 3;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] inst_de = NOP, inst_mw = NOP;
    logic        br_taken = 1'b0, irq = 1'b0, mie = 1'b0;
    logic        flush, stall, fwd_a, fwd_b, rf_wen_mw, mem_rd_mw, mem_wr_mw, csr_wr_mw, trap_req, irq_ack;
    logic [1:0]  wb_sel_mw;

    int          tests = 0, fails = 0;
    int          m_st = S_IDLE;
    logic [5:0]  m_ctrl = 6'd0;
    logic        m_sf = 1'b0;
    logic [5:0]  exp_q[$];

    pipeline_ctrl #(.BUS_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .inst_de(inst_de), .inst_mw(inst_mw), .br_taken(br_taken),
        .irq(irq), .mie(mie), .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .rf_wen_mw(rf_wen_mw), .mem_rd_mw(mem_rd_mw), .mem_wr_mw(mem_wr_mw), .wb_sel_mw(wb_sel_mw),
        .csr_wr_mw(csr_wr_mw), .trap_req(trap_req), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // {rf_wen, mem_rd, mem_wr, wb_sel[1:0], csr_wr} expected for an instruction leaving DE
    function automatic logic [5:0] dec(input logic [31:0] i);
        logic w;
        w = i[11:7] != 5'd0;
        case (i[6:0])
            7'h37, 7'h17, 7'h13, 7'h33: return {w, 5'b00000};
            7'h6F, 7'h67:               return {w, 5'b00100};
            7'h03:                      return {w, 5'b10010};
            7'h23:                      return 6'b001000;
            7'h73:                      return (i[14:12] != 3'd0) ? {w, 5'b00111} : 6'd0;
            default:                    return 6'd0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [31:0] i);
        case (i[6:0])
            7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
            7'h73:   return (i[14:12] != 3'd0) && !i[14];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [31:0] i);
        return i[6:0] == 7'h63 || i[6:0] == 7'h23 || i[6:0] == 7'h33;
    endfunction

    function automatic logic [11:0] outs();
        return {flush, stall, fwd_a, fwd_b, trap_req, irq_ack,
                rf_wen_mw, mem_rd_mw, mem_wr_mw, wb_sel_mw, csr_wr_mw};
    endfunction

    task automatic step(input string tag, input logic [31:0] de, input logic [31:0] mw,
                        input logic br, input logic ir, input logic me);
        logic e_flush, ra, rb, e_stall, e_fa, e_fb, mw_ctl;
        inst_de = de; inst_mw = mw; br_taken = br; irq = ir; mie = me;
        #2;
        e_flush = br || mw == MRET || m_st == S_TRAP || m_st == S_TF;
        ra = m_ctrl[5] && reads_rs1(de) && de[19:15] != 5'd0 && de[19:15] == mw[11:7];
        rb = m_ctrl[5] && reads_rs2(de) && de[24:20] != 5'd0 && de[24:20] == mw[11:7];
`ifdef PIPE_FWD_EN
        e_fa = ra; e_fb = rb; e_stall = 1'b0;
`else
        e_fa = 1'b0; e_fb = 1'b0; e_stall = (ra || rb) && !m_sf && !e_flush;
`endif
        check({tag, "/comb"}, {6'd0, flush, stall, fwd_a, fwd_b, trap_req, irq_ack},
              {6'd0, e_flush, e_stall, e_fa, e_fb, m_st == S_TRAP, m_st == S_TF});
        exp_q.push_back((m_st == S_TRAP || e_stall) ? 6'd0 : dec(de));
        m_sf = e_stall;
        mw_ctl = mw[6:0] == 7'h63 || mw[6:0] == 7'h6F || mw[6:0] == 7'h67 || mw == MRET;
        case (m_st)
            S_IDLE:  if (ir && me) m_st = (mw_ctl || br) ? S_DRAIN : S_TRAP;
            S_DRAIN: m_st = ir ? S_TRAP : S_IDLE;
            S_TRAP:  m_st = S_TF;
            default: m_st = S_IDLE;
        endcase
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check({tag, "/sb_empty"}, 12'd1, 12'd0);
        else begin
            m_ctrl = exp_q.pop_front();
            check({tag, "/mw"}, {6'd0, rf_wen_mw, mem_rd_mw, mem_wr_mw, wb_sel_mw, csr_wr_mw}, {6'd0, m_ctrl});
        end
    endtask

    initial begin
        #3;
        check("reset", outs(), 12'd0);
        @(posedge clk);
        #1;
        check("reset_held", outs(), 12'd0);
        rst = 1'b1;
        step("addi",     ADDI1, NOP,   1'b0, 1'b0, 1'b0);
        step("raw_ab",   ADD2,  ADDI1, 1'b0, 1'b0, 1'b0);
        step("raw_hold", ADD2,  NOP,   1'b0, 1'b0, 1'b0);
        step("lw",       LW5,   ADD2,  1'b0, 1'b0, 1'b0);
        step("lw_hold",  LW5,   NOP,   1'b0, 1'b0, 1'b0);
        step("sw_rs2",   SW5,   LW5,   1'b0, 1'b0, 1'b0);
        step("sw_hold",  SW5,   NOP,   1'b0, 1'b0, 1'b0);
        step("rd_x0",    ADD0,  SW5,   1'b0, 1'b0, 1'b0);
        step("csr",      CSRW6, ADD0,  1'b0, 1'b0, 1'b0);
        step("jal_br",   JAL1,  CSRW6, 1'b1, 1'b0, 1'b0);
        step("after_br", NOP,   JAL1,  1'b0, 1'b0, 1'b0);
        step("mret",     NOP,   MRET,  1'b0, 1'b0, 1'b0);
        step("mret_end", NOP,   NOP,   1'b0, 1'b0, 1'b0);
        step("irq",      ADDI3, ADD2,  1'b0, 1'b1, 1'b1);
        step("trap_br",  ADDI3, ADDI3, 1'b1, 1'b1, 1'b1);
        step("tflush",   NOP,   NOP,   1'b0, 1'b1, 1'b0);
        step("mie_off",  NOP,   NOP,   1'b0, 1'b1, 1'b0);
        step("mie_on",   NOP,   NOP,   1'b0, 1'b1, 1'b1);
        step("trap2",    NOP,   NOP,   1'b0, 1'b1, 1'b0);
        step("tflush2",  NOP,   NOP,   1'b0, 1'b0, 1'b0);
        step("irq_jal",  NOP,   JAL1,  1'b0, 1'b1, 1'b1);
        step("drain",    NOP,   NOP,   1'b0, 1'b1, 1'b0);
        step("trap3",    NOP,   NOP,   1'b0, 1'b1, 1'b0);
        step("tflush3",  NOP,   NOP,   1'b0, 1'b0, 1'b0);
        step("irq_beq",  NOP,   BEQ,   1'b0, 1'b1, 1'b1);
        step("drop",     NOP,   NOP,   1'b0, 1'b0, 1'b0);
        step("idle",     NOP,   NOP,   1'b0, 1'b0, 1'b0);
        step("irq_brt",  NOP,   NOP,   1'b1, 1'b1, 1'b1);
        step("drain2",   NOP,   NOP,   1'b0, 1'b1, 1'b0);
        step("trap4",    ADDI3, NOP,   1'b0, 1'b0, 1'b0);
        inst_de = NOP; inst_mw = NOP; br_taken = 1'b0; irq = 1'b0; mie = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_in_tf", outs(), 12'd0);
        m_st = S_IDLE; m_ctrl = 6'd0; m_sf = 1'b0;
        @(posedge clk);
        #1;
        check("rst_no_ack", outs(), 12'd0);
        rst = 1'b1;
        step("post_rst", ADDI1, NOP,   1'b0, 1'b0, 1'b0);
        step("post_raw", ADD2,  ADDI1, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
